hicore_irq_arb: RTL and testbench
=================================

# hicore_irq_arb

Parametrised external-interrupt arbiter for the HiCore RV32 core; it generalises the single `m_ext_irq` line into N_IRQ prioritised, individually enabled sources. Each source is level- or edge-sensitive, and a claim/complete handshake tracks the one interrupt in service. The block sits between the SoC interrupt sources and the core's `m_ext_irq` input. The trap handler uses the claim port to read the winning ID and the complete port to retire it.

## Interface
- N_IRQ, 8, number of external sources (1..32)
- ID_W, `$clog2(N_IRQ)` (min 1), claim/complete ID width
- SYNC_STAGES, 2, synchroniser depth (used only when HICORE_IRQ_SYNC_EN is defined; ≥2)
- EDGE_MASK, {N_IRQ{1'b0}}, bit i = 1 → source i edge-sensitive (rising), 0 → level-sensitive
---
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- irq_src  in  N_IRQ  raw interrupt sources
- irq_en  in  N_IRQ  per-source enable
- m_ext_irq  out  1  registered interrupt request to core
- claim_req  in  1  single-cycle claim strobe
- claim_ack  out  1  pulse, cycle after claim_req
- claim_id  out  ID_W  winning ID, valid with claim_ack
- claim_null  out  1  with claim_ack: nothing claimable
- complete_valid  in  1  complete strobe
- complete_id  in  ID_W  ID being retired
- bad_complete  out  1  pulse: complete rejected

## Operation
- Reset values:
  - all outputs 0
  - pending 0, src_q 0, in_svc_id 0, FSM IDLE
- Edge source:
  - rising edge (s & ~src_q) sets pending[i]
  - a claim of i clears pending[i]
  - when a set and a clear of the same bit occur in one cycle, set wins
  - an edge present at reset release (src_q = 0) is captured
- Level source:
  - pending[i] = registered level
  - never cleared by a claim; masked while i is in service
- Eligible = pending & irq_en & ~(in-service mask). Priority is fixed: the lowest index wins.
- FSM:
  - IDLE → PENDING when eligible ≠ 0
  - PENDING → IDLE when eligible drops to 0 without a claim
  - PENDING → SERVICE on claim_req; latches in_svc_id
  - SERVICE → IDLE on complete_valid with complete_id == in_svc_id
- m_ext_irq = (state == PENDING), registered.
- claim_req outside PENDING: claim_ack = 1, claim_null = 1, claim_id = 0; no state change.
- Complete rejected (bad_complete pulse, no state change):
  - complete_valid outside SERVICE
  - complete_valid with a mismatched ID
- claim_req and complete_valid in the same cycle: complete is evaluated against the pre-cycle state and claim is ignored. A new claim is needed after the FSM returns through PENDING.
- rst mid-service: immediate return to reset values; the in-service interrupt is dropped.

## Timing
- Source sampled in cycle 0 (no sync):
  - pending visible cycle 1
  - FSM in PENDING and m_ext_irq high cycle 2
- Sync compiled in: add SYNC_STAGES cycles.
- claim_req in cycle c (PENDING):
  - claim_ack, claim_id and claim_null in cycle c+1, one cycle wide
  - m_ext_irq low from c+1
- complete_valid accepted in cycle c: the FSM is IDLE in c+1. A still-eligible source re-raises m_ext_irq at c+2.
- bad_complete: one-cycle pulse, one cycle after the strobe.
- Maximum throughput: one interrupt per 4 cycles (raise, claim, ack, complete).

## Configuration
- HICORE_IRQ_SYNC_EN defined: each irq_src bit passes a SYNC_STAGES-flop synchroniser (reset 0) before edge and level logic.
- Macro undefined: sources are assumed synchronous to clk and are sampled directly; SYNC_STAGES is ignored.

## Structure
- Package hicore_irq_pkg holds:
  - FSM state enum (IDLE, PENDING, SERVICE)
  - function for the lowest-set-bit index
  - ID_W helper (clog2 with min 1)
- Sub-module hicore_irq_sync: per-source synchroniser plus src_q register and rising-edge detect; instantiated N_IRQ wide.
- Top: pending, priority encoder, FSM and handshake.

## Test plan
- N_IRQ=8, no sync, level src 3 high, irq_en=0xFF:
  - m_ext_irq high 2 cycles later
  - claim → claim_id=3, claim_null=0
  - complete(3) with src still high → m_ext_irq re-raised 2 cycles after complete
- Edge src 5 and level src 2 rise together:
  - claim → ID 2
  - complete(2) → re-raise; claim → ID 5; pending[5] clears
- irq_en[4]=0 with src 4 pending:
  - m_ext_irq stays low
  - setting irq_en[4]=1 → m_ext_irq high next cycle
- Error cases:
  - claim in IDLE → claim_ack=1, claim_null=1, claim_id=0
  - complete(1) while serving 6 → bad_complete=1, state remains SERVICE
- rst asserted in SERVICE → all outputs 0 next cycle; an edge source high at release is captured and serviced.
- HICORE_IRQ_SYNC_EN, SYNC_STAGES=3 → src-to-m_ext_irq latency is 5 cycles.

Source files
------------

// File: rtl/hicore_irq_pkg.sv
// Shared types and helpers for the HiCore external-interrupt arbiter.
package hicore_irq_pkg;

    localparam int MAX_IRQ = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Claim/complete ID width: clog2 of the source count, never below one bit.
    function automatic int id_width(input int n_irq);
        return (n_irq < 2) ? 1 : $clog2(n_irq);
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set_idx(input logic [MAX_IRQ-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/hicore_irq_sync.sv
// Source conditioning: optional synchroniser (HICORE_IRQ_SYNC_EN), sampled-level
// register and rising-edge detect for every interrupt source.
module hicore_irq_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] irq_src,
    output logic [WIDTH-1:0] src_s,
    output logic [WIDTH-1:0] src_rise
);

    logic [WIDTH-1:0] src_q;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("hicore_irq_sync: SYNC_STAGES must be at least 2");
    end

`ifdef HICORE_IRQ_SYNC_EN
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign src_s = sync_q[SYNC_STAGES-1];
`else
    assign src_s = irq_src;
`endif

    // src_q resets to 0, so a source already high at reset release reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) src_q <= '0;
        else     src_q <= src_s;
    end

    assign src_rise = src_s & ~src_q;

endmodule

// File: rtl/hicore_irq_arb.sv
// N-source fixed-priority external-interrupt arbiter with claim/complete handshake.
// Define HICORE_IRQ_SYNC_EN to put a SYNC_STAGES-deep synchroniser on every source.
module hicore_irq_arb
    import hicore_irq_pkg::*;
#(
    parameter int               N_IRQ       = 8,
    parameter int               ID_W        = id_width(N_IRQ),
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic [N_IRQ-1:0] irq_en,
    output logic             m_ext_irq,
    input  logic             claim_req,
    output logic             claim_ack,
    output logic [ID_W-1:0]  claim_id,
    output logic             claim_null,
    input  logic             complete_valid,
    input  logic [ID_W-1:0]  complete_id,
    output logic             bad_complete
);

    irq_state_e       state, next_state;
    logic [ID_W-1:0]  in_svc_id, next_svc_id;
    logic [N_IRQ-1:0] src_s, src_rise;
    logic [N_IRQ-1:0] pending, svc_mask, eligible, win_onehot, clr_mask;
    logic [ID_W-1:0]  winner;
    logic             claim_take, complete_ok;

    hicore_irq_sync #(
        .WIDTH       (N_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .src_s    (src_s),
        .src_rise (src_rise)
    );

    // NOTE: every variable written in an always_comb gets a default first; a path that leaves one unassigned infers a latch.
    always_comb begin
        svc_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            svc_mask[i] = (state == ST_SERVICE) && (in_svc_id == ID_W'(i));
        end
    end

    assign eligible   = pending & irq_en & ~svc_mask;
    assign win_onehot = eligible & (~eligible + N_IRQ'(1));
    assign winner     = ID_W'(lowest_set_idx(MAX_IRQ'(eligible)));

    always_comb begin
        next_state  = state;
        next_svc_id = in_svc_id;
        claim_take  = 1'b0;
        complete_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eligible != '0) next_state = ST_PENDING;
            end
            ST_PENDING: begin
                // A complete in the same cycle is rejected and the claim is answered as null.
                if (claim_req && !complete_valid && (eligible != '0)) begin
                    next_state  = ST_SERVICE;
                    next_svc_id = winner;
                    claim_take  = 1'b1;
                end else if (eligible == '0) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (complete_valid && (complete_id == in_svc_id)) begin
                    next_state  = ST_IDLE;
                    complete_ok = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign clr_mask = claim_take ? win_onehot : '0;

    // Edge bits: a new rising edge beats a same-cycle claim clear. Level bits track the sampled source.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (EDGE_MASK & ((pending & ~clr_mask) | src_rise)) | (~EDGE_MASK & src_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_svc_id    <= '0;
            m_ext_irq    <= 1'b0;
            claim_ack    <= 1'b0;
            claim_id     <= '0;
            claim_null   <= 1'b0;
            bad_complete <= 1'b0;
        end else begin
            state        <= next_state;
            in_svc_id    <= next_svc_id;
            m_ext_irq    <= (next_state == ST_PENDING);
            claim_ack    <= claim_req;
            claim_id     <= claim_take ? winner : '0;
            claim_null   <= claim_req && !claim_take;
            bad_complete <= complete_valid && !complete_ok;
        end
    end

endmodule

// File: tb/tb_hicore_irq_arb.sv
// Scoreboard bench for hicore_irq_arb: directed vectors push expected claim/complete
// responses; a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_hicore_irq_arb;

    localparam int               N_IRQ       = 8;
    localparam int               ID_W        = 3;
    localparam int               SYNC_STAGES = 3;
    localparam logic [N_IRQ-1:0] EDGE_MASK   = 8'b0010_0000;
`ifdef HICORE_IRQ_SYNC_EN
    localparam int               LAT         = 2 + SYNC_STAGES;
`else
    localparam int               LAT         = 2;
`endif

    logic             clk;
    logic             rst;
    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_en;
    logic             m_ext_irq;
    logic             claim_req;
    logic             claim_ack;
    logic [ID_W-1:0]  claim_id;
    logic             claim_null;
    logic             complete_valid;
    logic [ID_W-1:0]  complete_id;
    logic             bad_complete;

    typedef struct {
        bit is_claim;
        int id;
        bit nul;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    hicore_irq_arb #(
        .N_IRQ       (N_IRQ),
        .ID_W        (ID_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MASK   (EDGE_MASK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .irq_en         (irq_en),
        .m_ext_irq      (m_ext_irq),
        .claim_req      (claim_req),
        .claim_ack      (claim_ack),
        .claim_id       (claim_id),
        .claim_null     (claim_null),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .bad_complete   (bad_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, 32'(m_ext_irq), 32'(exp));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_irq"}, 32'(m_ext_irq), 0);
        check({name, "_ack"}, 32'(claim_ack), 0);
        check({name, "_id"}, 32'(claim_id), 0);
        check({name, "_null"}, 32'(claim_null), 0);
        check({name, "_bad"}, 32'(bad_complete), 0);
    endtask

    // Sources were driven this cycle: low for LAT-1 cycles, then high.
    task automatic expect_raise(input string name);
        for (int i = 1; i < LAT; i++) begin
            step();
            check_irq({name, "_early"}, 1'b0);
        end
        step();
        check_irq(name, 1'b1);
    endtask

    task automatic do_claim(input int id, input bit nul);
        claim_req = 1'b1;
        exp_q.push_back('{1'b1, id, nul, cyc + 1});
        step();
        claim_req = 1'b0;
    endtask

    task automatic do_complete(input int id, input bit bad);
        complete_valid = 1'b1;
        complete_id    = ID_W'(id);
        if (bad) exp_q.push_back('{1'b0, 0, 1'b0, cyc + 1});
        step();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic score(input bit is_claim);
        exp_t e;
        if (exp_q.size() == 0) begin
            check(is_claim ? "spurious_claim_ack" : "spurious_bad_complete",
                  32'(is_claim ? claim_ack : bad_complete), 0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_claim), 32'(e.is_claim));
            check("event_cycle", cyc, e.cyc);
            if (is_claim) begin
                check("claim_id", 32'(claim_id), e.id);
                check("claim_null", 32'(claim_null), 32'(e.nul));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (claim_ack === 1'b1)    score(1'b1);
            if (bad_complete === 1'b1) score(1'b0);
        end
    end

    initial begin
        rst            = 1'b1;
        irq_src        = '0;
        irq_en         = '0;
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);
        check_irq("idle_after_reset", 1'b0);

        // Level source 3: raise, claim, re-raise after complete while still high.
        irq_en     = 8'hFF;
        irq_src[3] = 1'b1;
        expect_raise("t1_raise");
        do_claim(3, 1'b0);
        check_irq("t1_claim_drop", 1'b0);
        step(2);
        check_irq("t1_masked_in_service", 1'b0);
        do_complete(3, 1'b0);
        check_irq("t1_cmp_plus1", 1'b0);
        step();
        check_irq("t1_reraise", 1'b1);
        do_claim(3, 1'b0);
        irq_src[3] = 1'b0;
        step(2);
        do_complete(3, 1'b0);
        step(3);
        check_irq("t1_quiet", 1'b0);

        // Edge 5 and level 2 together; priority, then edge pending behaviour.
        irq_src[5] = 1'b1;
        irq_src[2] = 1'b1;
        expect_raise("t2_raise");
        do_claim(2, 1'b0);
        irq_src[5] = 1'b0;
        irq_src[2] = 1'b0;
        step(2);
        do_complete(2, 1'b0);
        check_irq("t2_cmp_plus1", 1'b0);
        step();
        check_irq("t2_reraise_edge", 1'b1);
        irq_src[5] = 1'b1;            // new edge in the same cycle as the claim of 5
        do_claim(5, 1'b0);
        step(2);
        do_complete(5, 1'b0);
        check_irq("t2_cmp5_plus1", 1'b0);
        step();
        check_irq("t2_set_wins", 1'b1);
        do_claim(5, 1'b0);
        step(2);
        do_complete(5, 1'b0);
        step(3);
        check_irq("t2_edge_cleared", 1'b0);
        irq_src[5] = 1'b0;

        // Disabled source stays silent until enabled.
        irq_en[4]  = 1'b0;
        irq_src[4] = 1'b1;
        step(LAT + 3);
        check_irq("t3_disabled", 1'b0);
        irq_en[4] = 1'b1;
        step();
        check_irq("t3_enabled", 1'b1);
        do_claim(4, 1'b0);
        irq_src[4] = 1'b0;
        step(2);
        do_complete(4, 1'b0);
        step(3);
        check_irq("t3_quiet", 1'b0);

        // Error cases: null claims and rejected completes.
        do_claim(0, 1'b1);
        step();
        do_complete(2, 1'b1);
        step();
        irq_src[6] = 1'b1;
        expect_raise("t4_raise");
        do_claim(6, 1'b0);
        irq_src[6] = 1'b0;
        step();
        do_complete(1, 1'b1);
        step();
        do_claim(0, 1'b1);
        step();
        check_irq("t4_still_service", 1'b0);
        do_complete(6, 1'b0);
        step(3);
        check_irq("t4_quiet", 1'b0);

        // Reset while in service; edge source high at release is captured.
        irq_src[1] = 1'b1;
        expect_raise("t5_raise");
        do_claim(1, 1'b0);
        step();
        rst        = 1'b1;
        irq_src[1] = 1'b0;
        irq_src[5] = 1'b1;
        step();
        check_all_zero("t5_reset");
        step();
        rst = 1'b0;
        expect_raise("t5_edge_at_release");
        do_claim(5, 1'b0);
        step(2);
        do_complete(5, 1'b0);
        step(3);
        check_irq("t5_quiet", 1'b0);
        irq_src = '0;

        step(3);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
